// File: rtl/branch_resolve_pkg.sv
// Shared constants and types for the branch resolution slice.
// Holds the fetch-side defines plus the resolver's local state encoding.
package branch_resolve_pkg;

    localparam int unsigned DEF_PC_SIZE    = 32;
    localparam logic [6:0]  OPCODE_BXX     = 7'b1100011;
    localparam int unsigned BXX_SEQ_OFFSET = 4;

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } br_state_t;

endpackage

// File: rtl/branch_resolve_pred_fifo.sv
// Synchronous circular FIFO with flush, full/empty and occupancy count.
// Reads are fall-through: rd_data always shows the entry at the read pointer.
module pred_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr && !flush) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/branch_resolve.sv
// Resolves fetch-time Bxx predictions against execute outcomes and drives
// the misprediction redirect (fail pc + fail imm) back to next-PC logic.
module branch_resolve
    import branch_resolve_pkg::*;
#(
    parameter int unsigned PC_SIZE     = DEF_PC_SIZE,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned RECOVER_CYC = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_valid,
    output logic                     push_ready,
    input  logic [PC_SIZE-1:0]       push_pc,
    input  logic [PC_SIZE-1:0]       push_imm,
    input  logic                     push_take,
    input  logic                     res_valid,
    input  logic                     res_taken,
    output logic                     predict_fail,
    output logic [PC_SIZE-1:0]       bxx_fail_pc,
    output logic [PC_SIZE-1:0]       bxx_fail_imm,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     underflow_err
);

    localparam int unsigned EW = 2 * PC_SIZE + 1;
    localparam int unsigned RW = $clog2(RECOVER_CYC + 1);

    br_state_t          state;
    logic [RW-1:0]      rec_cnt;

    logic [EW-1:0]      head;
    logic [PC_SIZE-1:0] head_pc;
    logic [PC_SIZE-1:0] head_imm;
    logic               head_take;
    logic               fifo_full;
    logic               fifo_empty;

    logic               res_acc;
    logic               mismatch;
    logic               push_acc;

    assign {head_pc, head_imm, head_take} = head;

    assign push_ready = (state == RUN) && !fifo_full;
    assign busy       = (state == RECOVER);
    assign res_acc    = res_valid && (state == RUN) && !fifo_empty;
    assign mismatch   = res_acc && (head_take != res_taken);
    // Younger entries are wrong-path on a mismatch, so a same-cycle push is dropped too.
    assign push_acc   = push_valid && push_ready && !mismatch;

    pred_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_pred_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (mismatch),
        .wr_en   (push_acc),
        .wr_data ({push_pc, push_imm, push_take}),
        .rd_en   (res_acc),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (occupancy)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= RUN;
            rec_cnt       <= '0;
            predict_fail  <= 1'b0;
            bxx_fail_pc   <= '0;
            bxx_fail_imm  <= '0;
            underflow_err <= 1'b0;
        end else begin
            predict_fail <= 1'b0;
            case (state)
                RUN: begin
                    if (res_valid && fifo_empty) begin
                        underflow_err <= 1'b1;
                    end
                    if (mismatch) begin
                        state        <= RECOVER;
                        rec_cnt      <= RW'(RECOVER_CYC - 1);
                        predict_fail <= 1'b1;
                        bxx_fail_pc  <= head_pc;
                        // Predicted taken but fell through: resume at the next sequential Bxx slot.
                        bxx_fail_imm <= head_take ? PC_SIZE'(BXX_SEQ_OFFSET) : head_imm;
                    end
                end
                RECOVER: begin
                    if (rec_cnt == '0) begin
                        state <= RUN;
                    end else begin
                        rec_cnt <= rec_cnt - RW'(1);
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_resolve.sv
// Directed scoreboard bench for branch_resolve: expected redirects are queued
// by the stimulus and consumed by a monitor watching predict_fail.
module tb_branch_resolve;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        push_valid = 1'b0;
    logic        push_ready;
    logic [31:0] push_pc = '0;
    logic [31:0] push_imm = '0;
    logic        push_take = 1'b0;
    logic        res_valid = 1'b0;
    logic        res_taken = 1'b0;
    logic        predict_fail;
    logic [31:0] bxx_fail_pc;
    logic [31:0] bxx_fail_imm;
    logic        busy;
    logic [2:0]  occupancy;
    logic        underflow_err;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_imm_q[$];

    logic [31:0] m_pc[$];
    logic [31:0] m_imm[$];
    logic        m_take[$];

    branch_resolve #(
        .PC_SIZE     (32),
        .DEPTH       (4),
        .RECOVER_CYC (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .push_valid    (push_valid),
        .push_ready    (push_ready),
        .push_pc       (push_pc),
        .push_imm      (push_imm),
        .push_take     (push_take),
        .res_valid     (res_valid),
        .res_taken     (res_taken),
        .predict_fail  (predict_fail),
        .bxx_fail_pc   (bxx_fail_pc),
        .bxx_fail_imm  (bxx_fail_imm),
        .busy          (busy),
        .occupancy     (occupancy),
        .underflow_err (underflow_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_fail(input logic [31:0] pc, input logic [31:0] imm);
        exp_pc_q.push_back(pc);
        exp_imm_q.push_back(imm);
    endtask

    task automatic set_push(input logic v, input logic [31:0] pc, input logic [31:0] imm, input logic tk);
        push_valid = v;
        push_pc    = pc;
        push_imm   = imm;
        push_take  = tk;
    endtask

    // Monitor: every observed fail pulse must match the oldest queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && predict_fail) begin
                if (exp_pc_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_fail actual=1 required=0 pc=%h", bxx_fail_pc);
                end else begin
                    logic [31:0] epc;
                    logic [31:0] eimm;
                    epc  = exp_pc_q.pop_front();
                    eimm = exp_imm_q.pop_front();
                    chk("mon_fail_pc", bxx_fail_pc, epc);
                    chk("mon_fail_imm", bxx_fail_imm, eimm);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_push_ready", 32'(push_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_fail", 32'(predict_fail), 32'd0);
        chk("rst_uflow", 32'(underflow_err), 32'd0);

        // 1: correct not-taken prediction retires silently
        set_push(1'b1, 32'h100, 32'h20, 1'b0);
        tick();
        set_push(1'b0, '0, '0, 1'b0);
        chk("t1_occ1", 32'(occupancy), 32'd1);
        res_valid = 1'b1; res_taken = 1'b0;
        tick();
        res_valid = 1'b0;
        chk("t1_occ0", 32'(occupancy), 32'd0);
        chk("t1_ready", 32'(push_ready), 32'd1);
        chk("t1_nofail", 32'(predict_fail), 32'd0);

        // 2: predicted not-taken, actually taken -> redirect to pc+imm
        set_push(1'b1, 32'h200, 32'hFFFF_FFF0, 1'b0);
        tick();
        set_push(1'b0, '0, '0, 1'b0);
        res_valid = 1'b1; res_taken = 1'b1;
        expect_fail(32'h200, 32'hFFFF_FFF0);
        tick();
        res_valid = 1'b0;
        chk("t2_fail", 32'(predict_fail), 32'd1);
        chk("t2_busy1", 32'(busy), 32'd1);
        chk("t2_occ", 32'(occupancy), 32'd0);
        chk("t2_ready0", 32'(push_ready), 32'd0);
        tick();
        chk("t2_fail_off", 32'(predict_fail), 32'd0);
        chk("t2_busy2", 32'(busy), 32'd1);
        tick();
        chk("t2_busy_end", 32'(busy), 32'd0);
        chk("t2_ready1", 32'(push_ready), 32'd1);

        // 3: predicted taken, actually not taken -> offset 4, whole queue flushed
        for (int i = 0; i < 4; i++) begin
            set_push(1'b1, 32'h300 + 32'(4 * i), 32'h80, (i == 0));
            tick();
        end
        set_push(1'b0, '0, '0, 1'b0);
        chk("t3_occ4", 32'(occupancy), 32'd4);
        chk("t3_full_ready", 32'(push_ready), 32'd0);
        res_valid = 1'b1; res_taken = 1'b0;
        expect_fail(32'h300, 32'd4);
        tick();
        res_valid = 1'b0;
        chk("t3_flush", 32'(occupancy), 32'd0);
        set_push(1'b1, 32'h3F0, 32'h8, 1'b0);
        tick();
        chk("t3_busy_push_rej", 32'(occupancy), 32'd0);
        set_push(1'b0, '0, '0, 1'b0);
        tick();
        chk("t3_recovered", 32'(busy), 32'd0);
        chk("t3_occ_after", 32'(occupancy), 32'd0);

        // 4: full queue, simultaneous push+resolve, pointer wrap
        for (int i = 0; i < 4; i++) begin
            set_push(1'b1, 32'h400 + 32'(4 * i), 32'h1000 + 32'(i), i[0]);
            m_pc.push_back(push_pc); m_imm.push_back(push_imm); m_take.push_back(push_take);
            tick();
        end
        chk("t4_full_ready", 32'(push_ready), 32'd0);
        set_push(1'b1, 32'h410, 32'h1004, 1'b1);
        res_valid = 1'b1; res_taken = m_take[0];
        tick();
        void'(m_pc.pop_front()); void'(m_imm.pop_front()); void'(m_take.pop_front());
        res_valid = 1'b0;
        chk("t4_push_rej_occ3", 32'(occupancy), 32'd3);
        tick();
        m_pc.push_back(32'h410); m_imm.push_back(32'h1004); m_take.push_back(1'b1);
        set_push(1'b0, '0, '0, 1'b0);
        chk("t4_occ4", 32'(occupancy), 32'd4);
        while (m_take.size() > 0) begin
            res_valid = 1'b1; res_taken = m_take[0];
            tick();
            void'(m_pc.pop_front()); void'(m_imm.pop_front()); void'(m_take.pop_front());
        end
        res_valid = 1'b0;
        chk("t4_drained", 32'(occupancy), 32'd0);
        for (int i = 0; i < 10; i++) begin
            set_push(1'b1, 32'h500 + 32'(4 * i), 32'h2000 + 32'(i), i[0]);
            res_valid = (m_take.size() > 0);
            res_taken = (m_take.size() > 0) ? m_take[0] : 1'b0;
            tick();
            if (res_valid) begin
                void'(m_pc.pop_front()); void'(m_imm.pop_front()); void'(m_take.pop_front());
            end
            m_pc.push_back(push_pc); m_imm.push_back(push_imm); m_take.push_back(push_take);
        end
        chk("t4_wrap_occ", 32'(occupancy), 32'(m_take.size()));
        // Mismatch on the wrapped head while a push is presented: push must be dropped.
        set_push(1'b1, 32'h600, 32'h3000, 1'b0);
        res_valid = 1'b1; res_taken = !m_take[0];
        expect_fail(m_pc[0], m_take[0] ? 32'd4 : m_imm[0]);
        tick();
        m_pc.delete(); m_imm.delete(); m_take.delete();
        set_push(1'b0, '0, '0, 1'b0);
        res_valid = 1'b0;
        chk("t4_mis_occ", 32'(occupancy), 32'd0);
        chk("t4_mis_fail", 32'(predict_fail), 32'd1);
        tick();
        tick();
        chk("t4_recovered", 32'(busy), 32'd0);

        // 5: resolve on empty queue -> sticky underflow, no fail
        res_valid = 1'b1; res_taken = 1'b1;
        tick();
        res_valid = 1'b0;
        chk("t5_uflow", 32'(underflow_err), 32'd1);
        chk("t5_nofail", 32'(predict_fail), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        tick();
        tick();
        chk("t5_sticky", 32'(underflow_err), 32'd1);

        // 6: reset during recovery kills the pulse and clears everything
        set_push(1'b1, 32'h700, 32'h44, 1'b1);
        tick();
        set_push(1'b1, 32'h704, 32'h48, 1'b0);
        tick();
        set_push(1'b0, '0, '0, 1'b0);
        res_valid = 1'b1; res_taken = 1'b0;
        tick();
        res_valid = 1'b0;
        chk("t6_fail_pre_rst", 32'(predict_fail), 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_fail", 32'(predict_fail), 32'd0);
        chk("t6_rst_occ", 32'(occupancy), 32'd0);
        chk("t6_rst_uflow", 32'(underflow_err), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("t6_ready", 32'(push_ready), 32'd1);
        set_push(1'b1, 32'h800, 32'h10, 1'b1);
        tick();
        set_push(1'b0, '0, '0, 1'b0);
        chk("t6_occ1", 32'(occupancy), 32'd1);
        res_valid = 1'b1; res_taken = 1'b1;
        tick();
        res_valid = 1'b0;
        chk("t6_occ0", 32'(occupancy), 32'd0);
        chk("t6_nofail", 32'(predict_fail), 32'd0);

        tick();
        tick();
        chk("pending_fails", 32'(exp_pc_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
